// File: rtl/ao486_transducer_pkg.sv
// Shared definitions for the ao486 <-> L1.5 transducer: FSM encodings, L1.5
// request/return type codes, PCX size encodings and the word byte-swap helper.
package ao486_transducer_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ    = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT   = 2'd2;
    localparam logic [STATE_W-1:0] ST_STREAM = 2'd3;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] IMISS_RQ = 5'b10000;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;

    localparam logic [2:0] PCX_SZ_4B  = 3'b010;
    localparam logic [2:0] PCX_SZ_16B = 3'b111;

    // L1.5 returns big-endian words; the core expects little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/ao486_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first pending
// channel found when searching upward (with wrap) from ptr.
module ao486_rr_arbiter
    import ao486_transducer_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            idx = (32'(ptr) + off) % NUM_CH;
            if (!found && pending[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ao486_l15_transducer_mc.sv
// Multi-channel ao486 read transducer: captures per-channel requests, issues one
// L1.5 request at a time and streams the byte-swapped line back to the requester.
// Optional WAIT watchdog: define AO486_TRANSDUCER_TIMEOUT_EN.
module ao486_l15_transducer_mc
    import ao486_transducer_pkg::*;
#(
    parameter int unsigned       NUM_CH         = 3,
    parameter logic [NUM_CH-1:0] CODE_MASK      = NUM_CH'(1),
    parameter int unsigned       LINE_WORDS     = 4,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         core_req_do,
    input  logic [NUM_CH*32-1:0]      core_req_addr,
    output logic [NUM_CH-1:0]         core_req_busy,
    output logic [31:0]               core_resp_partial,
    output logic                      core_resp_partial_val,
    output logic [32*LINE_WORDS-1:0]  core_resp_line,
    output logic [NUM_CH-1:0]         core_resp_done,
    output logic                      core_resp_err,
    output logic                      ao486_int,
    output logic                      transducer_l15_val,
    output logic [4:0]                transducer_l15_rqtype,
    output logic [39:0]               transducer_l15_address,
    output logic [2:0]                transducer_l15_size,
    output logic                      transducer_l15_nc,
    output logic                      transducer_l15_req_ack,
    output logic [63:0]               transducer_l15_data,
    output logic [63:0]               transducer_l15_data_next_entry,
    output logic [3:0]                transducer_l15_amo_op,
    output logic [1:0]                transducer_l15_l1rplway,
    input  logic                      l15_transducer_val,
    input  logic                      l15_transducer_header_ack,
    input  logic [3:0]                l15_transducer_returntype,
    input  logic [63:0]               l15_transducer_data_0,
    input  logic [63:0]               l15_transducer_data_1,
    input  logic [63:0]               l15_transducer_data_2,
    input  logic [63:0]               l15_transducer_data_3
);

    localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;

    logic [STATE_W-1:0] state_q, state_d;
    logic [NUM_CH-1:0]  pending_q, pending_d, set_c, clr_c, grant_oh_c;
    logic [PTR_W-1:0]   ptr_q, ptr_d, grant_q, grant_d, gidx_c;
    logic [1:0]         k_q, k_d;
    logic [27:0]        addr_q [NUM_CH];
    logic [27:0]        addr_d [NUM_CH];
    logic [31:0]        words_q [4];
    logic [31:0]        words_d [4];
    logic [31:0]        resp_w_c [4];
    logic [27:0]        gaddr_c;
    logic               int_q, int_d, val_q, val_d, pval_q, pval_d;
    logic [4:0]         rqtype_q, rqtype_d;
    logic [39:0]        l15_addr_q, l15_addr_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        partial_q, partial_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [NUM_CH-1:0]  done_q, done_d;
    logic               is_code_c, sel_hi_c, match_c;
    logic [63:0]        beat0_c, beat1_c;
    logic [NUM_CH-1:0]  unused_addr_lo;

`ifdef AO486_TRANSDUCER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic             unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    ao486_rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_arb (
        .pending (pending_q),
        .ptr     (ptr_q),
        .grant   (grant_oh_c)
    );

    // One-hot grant to index, plus response word extraction.
    always_comb begin
        gidx_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_oh_c[i]) gidx_c = PTR_W'(i);
        end
        gaddr_c     = addr_q[gidx_c];
        is_code_c   = CODE_MASK[grant_q];
        sel_hi_c    = is_code_c && addr_q[grant_q][0];
        beat0_c     = sel_hi_c ? l15_transducer_data_2 : l15_transducer_data_0;
        beat1_c     = sel_hi_c ? l15_transducer_data_3 : l15_transducer_data_1;
        resp_w_c[0] = bswap32(beat0_c[63:32]);
        resp_w_c[1] = bswap32(beat0_c[31:0]);
        resp_w_c[2] = bswap32(beat1_c[63:32]);
        resp_w_c[3] = bswap32(beat1_c[31:0]);
        match_c     = l15_transducer_val &&
                      ((is_code_c  && l15_transducer_returntype == IFILL_RET) ||
                       (!is_code_c && l15_transducer_returntype == LOAD_RET));
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            unused_addr_lo[i] = ^core_req_addr[32*i +: 4];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        k_d        = k_q;
        words_d    = words_q;
        addr_d     = addr_q;
        int_d      = int_q;
        val_d      = val_q;
        rqtype_d   = rqtype_q;
        l15_addr_d = l15_addr_q;
        size_d     = size_q;
        partial_d  = partial_q;
        pval_d     = 1'b0;
        line_d     = line_q;
        done_d     = '0;
        set_c      = '0;
        clr_c      = '0;
`ifdef AO486_TRANSDUCER_TIMEOUT_EN
        err_d      = 1'b0;
        cnt_d      = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
`endif

        if (l15_transducer_val && l15_transducer_returntype == INT_RET &&
            l15_transducer_data_0[17:16] == 2'b01) begin
            int_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (int_q && |pending_q) begin
                    state_d = ST_REQ;
                    grant_d = gidx_c;
                    ptr_d   = (32'(gidx_c) == NUM_CH - 1) ? '0 : gidx_c + PTR_W'(1);
                    val_d   = 1'b1;
                    if (CODE_MASK[gidx_c]) begin
                        rqtype_d   = IMISS_RQ;
                        size_d     = PCX_SZ_4B;
                        l15_addr_d = {{8{gaddr_c[27]}}, gaddr_c[27:1], 5'b0};
                    end else begin
                        rqtype_d   = LOAD_RQ;
                        size_d     = PCX_SZ_16B;
                        l15_addr_d = {{8{gaddr_c[27]}}, gaddr_c, 4'b0};
                    end
                end
            end
            ST_REQ: begin
                if (l15_transducer_header_ack) begin
                    state_d = ST_WAIT;
                    val_d   = 1'b0;
                end
            end
            ST_WAIT: begin
                if (match_c) begin
                    state_d   = ST_STREAM;
                    words_d   = resp_w_c;
                    k_d       = '0;
                    partial_d = resp_w_c[0];
                    pval_d    = 1'b1;
                    line_d    = '0;
                    line_d[LINE_W-1 -: 32] = resp_w_c[0];
                end
`ifdef AO486_TRANSDUCER_TIMEOUT_EN
                else if (32'(cnt_q) == TIMEOUT_CYCLES - 1) begin
                    state_d         = ST_IDLE;
                    done_d[grant_q] = 1'b1;
                    clr_c[grant_q]  = 1'b1;
                    err_d           = 1'b1;
                    line_d          = '0;
                end
`endif
            end
            default: begin
                k_d       = k_q + 2'd1;
                partial_d = words_q[k_d];
                pval_d    = 1'b1;
                line_d[32*(LINE_WORDS-1-32'(k_d)) +: 32] = words_q[k_d];
                if (32'(k_d) == LINE_WORDS - 1) begin
                    state_d         = ST_IDLE;
                    done_d[grant_q] = 1'b1;
                    clr_c[grant_q]  = 1'b1;
                end
            end
        endcase

        // A channel re-arms only once its previous request has completed.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (core_req_do[i] && !pending_q[i]) begin
                set_c[i]  = 1'b1;
                addr_d[i] = core_req_addr[32*i+4 +: 28];
            end
        end
        pending_d = (pending_q & ~clr_c) | set_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            k_q        <= '0;
            int_q      <= 1'b0;
            val_q      <= 1'b0;
            rqtype_q   <= '0;
            l15_addr_q <= '0;
            size_q     <= '0;
            partial_q  <= '0;
            pval_q     <= 1'b0;
            line_q     <= '0;
            done_q     <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) addr_q[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) words_q[i] <= '0;
`ifdef AO486_TRANSDUCER_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            k_q        <= k_d;
            int_q      <= int_d;
            val_q      <= val_d;
            rqtype_q   <= rqtype_d;
            l15_addr_q <= l15_addr_d;
            size_q     <= size_d;
            partial_q  <= partial_d;
            pval_q     <= pval_d;
            line_q     <= line_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
`ifdef AO486_TRANSDUCER_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

`ifdef AO486_TRANSDUCER_TIMEOUT_EN
    assign core_resp_err = err_q;
`else
    assign core_resp_err = 1'b0;
`endif

    assign core_req_busy                  = pending_q;
    assign core_resp_partial              = partial_q;
    assign core_resp_partial_val          = pval_q;
    assign core_resp_line                 = line_q;
    assign core_resp_done                 = done_q;
    assign ao486_int                      = int_q;
    assign transducer_l15_val             = val_q;
    assign transducer_l15_rqtype          = rqtype_q;
    assign transducer_l15_address         = l15_addr_q;
    assign transducer_l15_size            = size_q;
    assign transducer_l15_nc              = 1'b0;
    assign transducer_l15_req_ack         = l15_transducer_val;
    assign transducer_l15_data            = '0;
    assign transducer_l15_data_next_entry = '0;
    assign transducer_l15_amo_op          = '0;
    assign transducer_l15_l1rplway        = '0;

endmodule

// File: tb/tb_ao486_l15_transducer_mc.sv
// Directed self-checking bench for ao486_l15_transducer_mc (NUM_CH=3, channel 0
// code, LINE_WORDS=4); the watchdog steps run only with AO486_TRANSDUCER_TIMEOUT_EN.
module tb_ao486_l15_transducer_mc;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req_do;
    logic [95:0]  req_addr;
    logic [2:0]   busy;
    logic [31:0]  partial;
    logic         pval;
    logic [127:0] line;
    logic [2:0]   done;
    logic         err;
    logic         int_flag;
    logic         t_val, t_nc, t_ack;
    logic [4:0]   t_rqtype;
    logic [39:0]  t_addr;
    logic [2:0]   t_size;
    logic [63:0]  t_data, t_data_next;
    logic [3:0]   t_amo;
    logic [1:0]   t_way;
    logic         l_val, l_hdr;
    logic [3:0]   l_rt;
    logic [63:0]  d0, d1, d2, d3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ao486_l15_transducer_mc #(.TIMEOUT_CYCLES(16)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .core_req_do                    (req_do),
        .core_req_addr                  (req_addr),
        .core_req_busy                  (busy),
        .core_resp_partial              (partial),
        .core_resp_partial_val          (pval),
        .core_resp_line                 (line),
        .core_resp_done                 (done),
        .core_resp_err                  (err),
        .ao486_int                      (int_flag),
        .transducer_l15_val             (t_val),
        .transducer_l15_rqtype          (t_rqtype),
        .transducer_l15_address         (t_addr),
        .transducer_l15_size            (t_size),
        .transducer_l15_nc              (t_nc),
        .transducer_l15_req_ack         (t_ack),
        .transducer_l15_data            (t_data),
        .transducer_l15_data_next_entry (t_data_next),
        .transducer_l15_amo_op          (t_amo),
        .transducer_l15_l1rplway        (t_way),
        .l15_transducer_val             (l_val),
        .l15_transducer_header_ack      (l_hdr),
        .l15_transducer_returntype      (l_rt),
        .l15_transducer_data_0          (d0),
        .l15_transducer_data_1          (d1),
        .l15_transducer_data_2          (d2),
        .l15_transducer_data_3          (d3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request through header handshake and response; eline is the
    // expected line with word0 in the MSBs.
    task automatic service(input string tag, input int ch, input logic [39:0] ea,
                           input logic [4:0] erq, input logic [2:0] esz,
                           input logic [3:0] rt, input int hold, input bit stack,
                           input logic [255:0] d, input logic [127:0] eline);
        int           n;
        logic [2:0]   eh;
        logic [127:0] part;
        n     = 0;
        eh    = '0;
        eh[ch] = 1'b1;
        while (t_val !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_val"}, 128'(t_val), 128'(1'b1));
        chk({tag, "_addr"}, 128'(t_addr), 128'(ea));
        chk({tag, "_rqtype"}, 128'(t_rqtype), 128'(erq));
        chk({tag, "_size"}, 128'(t_size), 128'(esz));
        chk({tag, "_nc"}, 128'(t_nc), 128'(1'b0));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold"}, {87'(0), t_val, t_rqtype, t_addr}, {87'(0), 1'b1, erq, ea});
        end
        l_hdr = 1'b1;
        tick();
        l_hdr = 1'b0;
        chk({tag, "_val_drop"}, 128'(t_val), 128'(1'b0));
        tick();
        if (stack) begin
            l_val = 1'b1;
            l_rt  = 4'b0100;
            #1;
            chk({tag, "_stack_ack"}, 128'(t_ack), 128'(1'b1));
            tick();
            l_val = 1'b0;
            chk({tag, "_stack_nodone"}, {125'(0), done}, 128'(0));
            tick();
            chk({tag, "_stack_nopval"}, 128'(pval), 128'(1'b0));
        end
        l_val = 1'b1;
        l_rt  = rt;
        {d0, d1, d2, d3} = d;
        tick();
        l_val = 1'b0;
        for (int j = 0; j < 4; j++) begin
            part = eline & ~({128{1'b1}} >> (32 * (j + 1)));
            chk({tag, "_pval"}, 128'(pval), 128'(1'b1));
            chk({tag, "_word"}, 128'(partial), 128'(eline[127 - 32*j -: 32]));
            chk({tag, "_line"}, line, part);
            chk({tag, "_done"}, 128'(done), (j == 3) ? 128'(eh) : 128'(0));
            if (j == 3) chk({tag, "_busy_clr"}, 128'(busy[ch]), 128'(1'b0));
            if (j < 3) tick();
        end
        tick();
        chk({tag, "_done_pulse"}, {126'(0), pval, |done}, 128'(0));
    endtask

    initial begin
        int   n;
        logic seen;
        rst = 1'b1; req_do = '0; req_addr = '0; l_val = 1'b0; l_hdr = 1'b0;
        l_rt = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) tick();
        chk("reset_outs", {busy, partial, pval, done, err, int_flag, t_val, t_rqtype, t_addr, t_size},
            128'(0));
        chk("reset_line", line, 128'(0));
        rst = 1'b0;
        tick();

        // Request captured while asleep, never issued.
        req_addr[31:0] = 32'h0000_1234;
        req_do = 3'b001;
        tick();
        req_do = 3'b000;
        repeat (3) tick();
        chk("gate_no_val", 128'(t_val), 128'(1'b0));
        chk("gate_busy", 128'(busy), 128'(3'b001));

        // INT_RET with wrong code bits: acked, no wake-up.
        l_val = 1'b1; l_rt = 4'b0111; d0 = 64'h0000_0000_0002_0000;
        #1;
        chk("int_bad_ack", 128'(t_ack), 128'(1'b1));
        tick();
        l_val = 1'b0;
        chk("int_bad_noset", 128'(int_flag), 128'(1'b0));
        chk("int_bad_no_val", 128'(t_val), 128'(1'b0));

        l_val = 1'b1; l_rt = 4'b0111; d0 = 64'h0000_0000_0001_0000;
        tick();
        l_val = 1'b0; d0 = '0;
        chk("int_set", 128'(int_flag), 128'(1'b1));

        service("code_hi", 0, 40'h00_0000_1220, 5'h10, 3'b010, 4'b0001, 5, 1'b0,
                {64'hdead_beef_cafe_f00d, 64'h0bad_c0de_1234_5678,
                 64'h0011_2233_4455_6677, 64'h8899_aabb_ccdd_eeff},
                128'h33221100_77665544_bbaa9988_ffeeddcc);

        // ST_ACK in WAIT is acked but does not complete.
        req_addr[95:64] = 32'h0000_0abc;
        req_do = 3'b100;
        tick();
        req_do = 3'b000;
        service("stack", 2, 40'h00_0000_0ab0, 5'h00, 3'b111, 4'b0000, 0, 1'b1,
                {64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                 64'haaaa_aaaa_aaaa_aaaa, 64'h5555_5555_5555_5555},
                128'h04030201_08070605_14131211_18171615);

        // Simultaneous requests from ptr 0; repeat request on ch0 is ignored.
        req_addr = {32'h0000_3ff0, 32'h8000_0048, 32'h0000_2010};
        req_do = 3'b111;
        tick();
        req_do = 3'b000;
        chk("batch_busy", 128'(busy), 128'(3'b111));
        req_addr[31:0] = 32'hffff_ffff;
        req_do = 3'b001;
        tick();
        req_do = 3'b000;
        req_addr[31:0] = 32'h0000_2010;
        service("batch_c0", 0, 40'h00_0000_2000, 5'h10, 3'b010, 4'b0001, 0, 1'b0,
                {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210},
                128'h67452301_efcdab89_98badcfe_10325476);
        service("batch_c1", 1, 40'hff_8000_0040, 5'h00, 3'b111, 4'b0000, 0, 1'b0,
                {64'ha0a1_a2a3_b0b1_b2b3, 64'hc0c1_c2c3_d0d1_d2d3,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444},
                128'ha3a2a1a0_b3b2b1b0_c3c2c1c0_d3d2d1d0);
        service("batch_c2", 2, 40'h00_0000_3ff0, 5'h00, 3'b111, 4'b0000, 0, 1'b0,
                {64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
                 64'h6666_6666_6666_6666, 64'h7777_7777_7777_7777},
                128'h01000000_02000000_03000000_04000000);

        // Single ch1 moves ptr to 2, so the next batch serves ch2 before ch0.
        req_addr[63:32] = 32'h0000_0100;
        req_do = 3'b010;
        tick();
        req_do = 3'b000;
        service("single_c1", 1, 40'h00_0000_0100, 5'h00, 3'b111, 4'b0000, 0, 1'b0,
                {64'h00ff_00ff_1122_3344, 64'h5566_7788_99aa_bbcc,
                 64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999},
                128'hff00ff00_44332211_88776655_ccbbaa99);
        req_addr[31:0]  = 32'h0000_0040;
        req_addr[95:64] = 32'h0000_0004;
        req_do = 3'b101;
        tick();
        req_do = 3'b000;
        service("rot_c2", 2, 40'h00_0000_0000, 5'h00, 3'b111, 4'b0000, 0, 1'b0,
                {64'h0a0b_0c0d_0e0f_1011, 64'h1213_1415_1617_1819,
                 64'hbbbb_bbbb_bbbb_bbbb, 64'hcccc_cccc_cccc_cccc},
                128'h0d0c0b0a_11100f0e_15141312_19181716);
        service("rot_c0", 0, 40'h00_0000_0040, 5'h10, 3'b010, 4'b0001, 0, 1'b0,
                {64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738,
                 64'hdddd_dddd_dddd_dddd, 64'heeee_eeee_eeee_eeee},
                128'h24232221_28272625_34333231_38373635);

`ifdef AO486_TRANSDUCER_TIMEOUT_EN
        req_addr[63:32] = 32'h0000_0300;
        req_do = 3'b010;
        tick();
        req_do = 3'b000;
        n = 0;
        while (t_val !== 1'b1 && n < 40) begin tick(); n++; end
        chk("to_val", 128'(t_val), 128'(1'b1));
        l_hdr = 1'b1;
        tick();
        l_hdr = 1'b0;
        n = 0;
        while (done === 3'b000 && n < 40) begin tick(); n++; end
        chk("to_cycles", 128'(n), 128'(16));
        chk("to_done_err", {124'(0), done, err}, {124'(0), 3'b010, 1'b1});
        tick();
        chk("to_err_pulse", {124'(0), done, err}, 128'(0));
        l_val = 1'b1; l_rt = 4'b0000;
        #1;
        chk("to_late_ack", 128'(t_ack), 128'(1'b1));
        tick();
        l_val = 1'b0;
        chk("to_late_drop", 128'(pval), 128'(1'b0));
`endif

        // Reset in the middle of a stream abandons it without a done.
        req_addr[63:32] = 32'h0000_0200;
        req_do = 3'b010;
        tick();
        req_do = 3'b000;
        n = 0;
        while (t_val !== 1'b1 && n < 40) begin tick(); n++; end
        chk("mrst_val", 128'(t_val), 128'(1'b1));
        l_hdr = 1'b1;
        tick();
        l_hdr = 1'b0;
        l_val = 1'b1; l_rt = 4'b0000;
        d0 = 64'h0102_0304_0506_0708; d1 = 64'h1112_1314_1516_1718;
        tick();
        l_val = 1'b0;
        chk("mrst_stream", {96'(0), partial}, 128'(32'h04030201));
        rst = 1'b1;
        tick();
        chk("mrst_outs", {busy, partial, pval, done, err, int_flag, t_val, t_rqtype, t_addr, t_size},
            128'(0));
        chk("mrst_line", line, 128'(0));
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | (|done) | pval;
        end
        chk("mrst_no_done", 128'(seen), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
